sync_fifo_prog: RTL and testbench

//  Single-clock FIFO; parametrised successor to the async FIFO, for same-domain buffering.

---
 rtl/sync_fifo_prog.sv | 152 +++++++++++++++
 tb/tb_sync_fifo_prog.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty thresholds,
// fill level, optional first-word-fall-through, sticky error flags and flush.
module sync_fifo_prog #(
    parameter int BITS      = 32,
    parameter int SIZE      = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      p_flush,
    input  logic                      p_write_en,
    input  logic [BITS-1:0]           p_write_data,
    output logic                      p_write_full,
    output logic                      p_write_almost_full,
    input  logic                      p_read_en,
    output logic [BITS-1:0]           p_read_data,
    output logic                      p_read_empty,
    output logic                      p_read_almost_empty,
    output logic [$clog2(SIZE+1)-1:0] p_level,
    output logic                      p_overflow,
    output logic                      p_underflow,
    input  logic                      p_clear_errors
);

    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int LW = $clog2(SIZE + 1);

    if (SIZE < 2) begin : g_bad_size
        $fatal(1, "sync_fifo_prog: SIZE must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > SIZE)) begin : g_bad_af
        $fatal(1, "sync_fifo_prog: AF_THRESH out of range 1..SIZE");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > SIZE - 1)) begin : g_bad_ae
        $fatal(1, "sync_fifo_prog: AE_THRESH out of range 0..SIZE-1");
    end

    logic [BITS-1:0] r_mem [0:SIZE-1];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_full;
    logic            r_empty;
    logic            r_almost_full;
    logic            r_almost_empty;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_write_acc;
    logic            w_read_acc;
    logic            w_write_do;
    logic            w_read_do;
    logic [AW-1:0]   w_wr_ptr_inc;
    logic [AW-1:0]   w_rd_ptr_inc;
    logic [LW-1:0]   w_level_nxt;

    assign w_write_acc = p_write_en & ~r_full;
    assign w_read_acc  = p_read_en & ~r_empty;
    // Flush overrides any accepted transfer in the same cycle.
    assign w_write_do  = w_write_acc & ~p_flush;
    assign w_read_do   = w_read_acc & ~p_flush;

    assign w_wr_ptr_inc = (r_wr_ptr == AW'(SIZE - 1)) ? AW'(0) : (r_wr_ptr + AW'(1));
    assign w_rd_ptr_inc = (r_rd_ptr == AW'(SIZE - 1)) ? AW'(0) : (r_rd_ptr + AW'(1));

    // Next fill level from the accepted transfers.
    always_comb begin
        w_level_nxt = r_level;
        if (p_flush) begin
            w_level_nxt = LW'(0);
        end else begin
            case ({w_write_do, w_read_do})
                2'b10:   w_level_nxt = r_level + LW'(1);
                2'b01:   w_level_nxt = r_level - LW'(1);
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // Storage array; contents are never reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_write_do) begin
            r_mem[r_wr_ptr] <= p_write_data;
        end
    end

    // Pointers, level and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= AW'(0);
            r_rd_ptr       <= AW'(0);
            r_level        <= LW'(0);
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (p_flush) begin
                r_wr_ptr <= AW'(0);
                r_rd_ptr <= AW'(0);
            end else begin
                if (w_write_do) r_wr_ptr <= w_wr_ptr_inc;
                if (w_read_do)  r_rd_ptr <= w_rd_ptr_inc;
            end
            r_level        <= w_level_nxt;
            r_full         <= (w_level_nxt == LW'(SIZE));
            r_empty        <= (w_level_nxt == LW'(0));
            r_almost_full  <= (w_level_nxt >= LW'(AF_THRESH));
            r_almost_empty <= (w_level_nxt <= LW'(AE_THRESH));
        end
    end

    // Sticky error flags; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (p_write_en && r_full)  r_overflow <= 1'b1;
            else if (p_clear_errors)   r_overflow <= 1'b0;
            if (p_read_en && r_empty)  r_underflow <= 1'b1;
            else if (p_clear_errors)   r_underflow <= 1'b0;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign p_read_data = r_empty ? {BITS{1'b0}} : r_mem[r_rd_ptr];
    end else begin : g_reg_read
        logic [BITS-1:0] r_read_data;

        // Registered read port: loads the head on each accepted read.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_read_data <= {BITS{1'b0}};
            end else if (w_read_do) begin
                r_read_data <= r_mem[r_rd_ptr];
            end
        end
        assign p_read_data = r_read_data;
    end

    assign p_write_full        = r_full;
    assign p_write_almost_full = r_almost_full;
    assign p_read_empty        = r_empty;
    assign p_read_almost_empty = r_almost_empty;
    assign p_level             = r_level;
    assign p_overflow          = r_overflow;
    assign p_underflow         = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: a registered-read and a fall-through FIFO driven by the same stimulus.
module tb_sync_fifo_prog;

    localparam int BITS = 32;
    localparam int SIZE = 12;
    localparam int AFT  = 10;
    localparam int AET  = 2;
    localparam int LW   = $clog2(SIZE + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            we = 1'b0;
    logic [BITS-1:0] wd = '0;
    logic            re = 1'b0;
    logic            clr = 1'b0;

    logic            full0, afull0, empty0, aempty0, ovf0, unf0;
    logic [BITS-1:0] rd0;
    logic [LW-1:0]   lvl0;
    logic            full1, afull1, empty1, aempty1, ovf1, unf1;
    logic [BITS-1:0] rd1;
    logic [LW-1:0]   lvl1;

    int              n_checks = 0;
    int              n_fail = 0;

    logic [BITS-1:0] q[$];
    int              m_level = 0;
    logic            m_ovf = 1'b0;
    logic            m_unf = 1'b0;
    logic [BITS-1:0] m_rd0 = '0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.BITS(BITS), .SIZE(SIZE), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .p_flush(flush),
        .p_write_en(we), .p_write_data(wd), .p_write_full(full0), .p_write_almost_full(afull0),
        .p_read_en(re), .p_read_data(rd0), .p_read_empty(empty0), .p_read_almost_empty(aempty0),
        .p_level(lvl0), .p_overflow(ovf0), .p_underflow(unf0), .p_clear_errors(clr)
    );

    sync_fifo_prog #(.BITS(BITS), .SIZE(SIZE), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .p_flush(flush),
        .p_write_en(we), .p_write_data(wd), .p_write_full(full1), .p_write_almost_full(afull1),
        .p_read_en(re), .p_read_data(rd1), .p_read_empty(empty1), .p_read_almost_empty(aempty1),
        .p_level(lvl1), .p_overflow(ovf1), .p_underflow(unf1), .p_clear_errors(clr)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_status();
        logic [63:0] lv;
        lv = 64'(m_level);
        check_eq("level0", 64'(lvl0), lv);
        check_eq("level1", 64'(lvl1), lv);
        check_eq("full", 64'(full0), 64'(m_level == SIZE));
        check_eq("empty", 64'(empty0), 64'(m_level == 0));
        check_eq("almost_full", 64'(afull0), 64'(m_level >= AFT));
        check_eq("almost_empty", 64'(aempty0), 64'(m_level <= AET));
        check_eq("full_fwft", 64'(full1), 64'(m_level == SIZE));
        check_eq("empty_fwft", 64'(empty1), 64'(m_level == 0));
        check_eq("overflow", 64'(ovf0), 64'(m_ovf));
        check_eq("underflow", 64'(unf0), 64'(m_unf));
        check_eq("overflow_fwft", 64'(ovf1), 64'(m_ovf));
        check_eq("underflow_fwft", 64'(unf1), 64'(m_unf));
        check_eq("read_data", 64'(rd0), 64'(m_rd0));
        if (q.size() > 0) check_eq("fwft_head", 64'(rd1), 64'(q[0]));
    endtask

    task automatic step(input logic i_we, input logic [BITS-1:0] i_wd, input logic i_re,
                        input logic i_fl, input logic i_clr);
        logic wacc, racc, set_o, set_u;
        we = i_we; wd = i_wd; re = i_re; flush = i_fl; clr = i_clr;
        wacc  = i_we && (m_level < SIZE);
        racc  = i_re && (m_level > 0);
        set_o = i_we && (m_level == SIZE);
        set_u = i_re && (m_level == 0);
        @(posedge clk);
        #1;
        if (i_fl) begin
            q.delete();
            m_level = 0;
        end else begin
            if (racc) begin
                m_rd0 = q.pop_front();
                m_level--;
            end
            if (wacc) begin
                q.push_back(i_wd);
                m_level++;
            end
        end
        m_ovf = set_o ? 1'b1 : (i_clr ? 1'b0 : m_ovf);
        m_unf = set_u ? 1'b1 : (i_clr ? 1'b0 : m_unf);
        we = 1'b0; re = 1'b0; flush = 1'b0; clr = 1'b0;
        check_status();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        we = 1'b0; re = 1'b0; flush = 1'b0; clr = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_level = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rd0 = '0;
        check_status();
        check_eq("reset_rd_fwft", 64'(rd1), 64'h0);
    endtask

    initial begin
        // 1: reset
        do_reset(2);

        // 2: fill, overflow, drain
        for (int i = 0; i < SIZE; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
        check_eq("ovf_after_13th", 64'(ovf0), 64'h1);
        for (int i = 0; i < SIZE; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("last_read_AB", 64'(rd0), 64'hAB);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // 3: pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(r * 16 + i), 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < SIZE; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SIZE; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 4: simultaneous read/write
        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h400 + 32'(i), 1'b1, 1'b0, 1'b0);
        check_eq("level_held_5", 64'(lvl0), 64'd5);
        for (int i = 0; i < 7; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD, 1'b1, 1'b0, 1'b0);
        check_eq("full_rw_level", 64'(lvl0), 64'd11);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 5: fall-through head, underflow, clear
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        check_eq("fwft_55", 64'(rd1), 64'h55);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("underflow_set", 64'(unf1), 64'h1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("underflow_clear", 64'(unf1), 64'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 6: flush and reset mid-operation
        for (int i = 0; i < 7; i++) step(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7FF, 1'b0, 1'b1, 1'b0);
        check_eq("flush_level", 64'(lvl0), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h800 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        do_reset(1);
        check_eq("reset_mid_level", 64'(lvl0), 64'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 32'h900 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
